// File: rtl/dac_pkg.sv
// Shared constants and state encoding for the OCXO/VCXO tuning DAC driver.
package dac_pkg;

    localparam int DAC_BITS      = 16;
    localparam int SCLK_HALF_DEF = 4;
    localparam int CS_HIGH_DEF   = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } dac_state_t;

endpackage

// File: rtl/dac_driver_spi_shift.sv
// Frame shifter: loads a DAC code and clocks it out MSB-first,
// one bit per sclk period, followed by a trailing half-period.
module dac_spi_shift
    import dac_pkg::*;
#(
    parameter int SCLK_HALF = SCLK_HALF_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                abort,
    input  logic                load,
    input  logic [DAC_BITS-1:0] load_val,
    output logic                sclk,
    output logic                sin,
    output logic                done
);

    localparam int PH_W      = $clog2(SCLK_HALF + 1);
    localparam int HALF_W    = $clog2(2 * DAC_BITS + 2);
    localparam int LAST_HALF = 2 * DAC_BITS;

    logic                busy_q, busy_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [HALF_W-1:0]   half_q, half_d;
    logic [DAC_BITS-1:0] sreg_q, sreg_d;
    logic                sclk_q, sclk_d;
    logic                sin_q, sin_d;
    logic                half_end;

    assign half_end = busy_q && (phase_q == PH_W'(SCLK_HALF - 1));
    assign done     = half_end && (half_q == HALF_W'(LAST_HALF));
    assign sclk     = sclk_q;
    assign sin      = sin_q;

    always_comb begin
        busy_d  = busy_q;
        phase_d = phase_q;
        half_d  = half_q;
        sreg_d  = sreg_q;
        sclk_d  = sclk_q;
        sin_d   = sin_q;
        if (load) begin
            busy_d  = 1'b1;
            phase_d = '0;
            half_d  = '0;
            sreg_d  = load_val;
            sclk_d  = 1'b0;
            sin_d   = load_val[DAC_BITS-1];
        end else if (busy_q) begin
            phase_d = phase_q + 1'b1;
            if (half_end) begin
                phase_d = '0;
                half_d  = half_q + 1'b1;
                if (done) begin
                    busy_d = 1'b0;
                    sclk_d = 1'b0;
                    sin_d  = 1'b0;
                end else if (!half_q[0]) begin
                    sclk_d = 1'b1;
                end else begin
                    // Last bit stays on sin through the trailing half-period
                    sclk_d = 1'b0;
                    sreg_d = sreg_q << 1;
                    if (half_q != HALF_W'(LAST_HALF - 1)) begin
                        sin_d = sreg_q[DAC_BITS-2];
                    end
                end
            end
        end
        if (abort) begin
            busy_d = 1'b0;
            sclk_d = 1'b0;
            sin_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= 1'b0;
            phase_q <= '0;
            half_q  <= '0;
            sreg_q  <= '0;
            sclk_q  <= 1'b0;
            sin_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            phase_q <= phase_d;
            half_q  <= half_d;
            sreg_q  <= sreg_d;
            sclk_q  <= sclk_d;
            sin_q   <= sin_d;
        end
    end

endmodule

// File: rtl/dac_driver.sv
// Tick-paced serial driver for the 16-bit tuning DAC: decides when a
// frame goes out and frames it with dac_cs_n and the inter-frame gap.
module dac_driver
    import dac_pkg::*;
#(
    parameter int SCLK_HALF = SCLK_HALF_DEF,
    parameter int CS_HIGH   = CS_HIGH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tsc_1pps,
    input  logic                tsc_1ppms,
    input  logic                dac_ena,
    input  logic                dac_tri,
    input  logic [DAC_BITS-1:0] dac_val,
    output logic                dac_sclk,
    output logic                dac_cs_n,
    output logic                dac_sin
);

    localparam int GAP_W = $clog2(CS_HIGH + 1);

    dac_state_t          state_q, state_d;
    logic [DAC_BITS-1:0] last_val_q, last_val_d;
    logic                pending_q, pending_d;
    logic                cs_n_q, cs_n_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic                allowed;
    logic                trig;
    logic                load;
    logic                abort;
    logic                shift_done;

    assign allowed  = dac_ena && !dac_tri;
    assign trig     = tsc_1pps || (tsc_1ppms && (dac_val != last_val_q));
    assign dac_cs_n = cs_n_q;

    always_comb begin
        state_d    = state_q;
        last_val_d = last_val_q;
        pending_d  = pending_q;
        cs_n_d     = cs_n_q;
        gap_cnt_d  = gap_cnt_q;
        load       = 1'b0;
        abort      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (allowed && (trig || pending_q)) begin
                    load       = 1'b1;
                    last_val_d = dac_val;
                    pending_d  = 1'b0;
                    cs_n_d     = 1'b0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (allowed && tsc_1pps) begin
                    pending_d = 1'b1;
                end
                if (shift_done) begin
                    cs_n_d    = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (allowed && tsc_1pps) begin
                    pending_d = 1'b1;
                end
                if (gap_cnt_q == GAP_W'(CS_HIGH - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Tri-state drops everything; zeroed last_val forces a refresh later
        if (dac_tri) begin
            state_d    = IDLE;
            pending_d  = 1'b0;
            last_val_d = '0;
            cs_n_d     = 1'b1;
            load       = 1'b0;
            abort      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_val_q <= '0;
            pending_q  <= 1'b0;
            cs_n_q     <= 1'b1;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_val_q <= last_val_d;
            pending_q  <= pending_d;
            cs_n_q     <= cs_n_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    dac_spi_shift #(
        .SCLK_HALF(SCLK_HALF)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .abort   (abort),
        .load    (load),
        .load_val(dac_val),
        .sclk    (dac_sclk),
        .sin     (dac_sin),
        .done    (shift_done)
    );

endmodule

// File: tb/tb_dac_driver.sv
// Bench for dac_driver: frame-level timing model compared every cycle,
// plus a serial capture monitor checked against hand-computed frames.
module tb_dac_driver;

    localparam int LOW_CLKS   = (2 * 16 + 1) * 4;
    localparam int FRAME_CLKS = LOW_CLKS + 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pps = 1'b0;
    logic        ms = 1'b0;
    logic        ena = 1'b0;
    logic        dac_tri = 1'b0;
    logic [15:0] val = 16'h0000;
    logic        dac_sclk;
    logic        dac_cs_n;
    logic        dac_sin;

    int n_cmp = 0;
    int n_bad = 0;

    dac_driver dut (
        .clk      (clk),
        .rst      (rst),
        .tsc_1pps (pps),
        .tsc_1ppms(ms),
        .dac_ena  (ena),
        .dac_tri  (dac_tri),
        .dac_val  (val),
        .dac_sclk (dac_sclk),
        .dac_cs_n (dac_cs_n),
        .dac_sin  (dac_sin)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, got, got, exp, exp, $time);
        end
    endtask

    // Frame-level model: a frame starts at edge m_start and occupies the
    // line for LOW_CLKS, the driver is busy for FRAME_CLKS after it.
    int          cyc = 0;
    int          m_start = -100000;
    logic [15:0] m_val = 16'h0000;
    logic [15:0] m_last = 16'h0000;
    logic        m_pend = 1'b0;

    initial begin : model
        bit idle;
        bit tick;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst || dac_tri) begin
                m_start = -100000;
                m_last  = 16'h0000;
                m_pend  = 1'b0;
            end else begin
                idle = (cyc > m_start + FRAME_CLKS);
                tick = pps || (ms && (val != m_last));
                if (idle) begin
                    if (ena && (tick || m_pend)) begin
                        m_start = cyc;
                        m_val   = val;
                        m_last  = val;
                        m_pend  = 1'b0;
                    end
                end else if (ena && pps) begin
                    m_pend = 1'b1;
                end
            end
        end
    end

    initial begin : compare
        int k;
        int h;
        logic [2:0] exp_o;
        forever begin
            @(negedge clk);
            k = cyc - m_start;
            exp_o = 3'b100;
            if (k >= 0 && k < LOW_CLKS) begin
                h = k / 4;
                exp_o[2] = 1'b0;
                exp_o[1] = h[0];
                exp_o[0] = (h < 32) ? m_val[15 - h / 2] : m_val[0];
            end
            chk("pins{cs_n,sclk,sin}", int'({dac_cs_n, dac_sclk, dac_sin}),
                int'(exp_o));
        end
    end

    int          frames = 0;
    logic [15:0] cap = 16'h0000;
    int          nbits = 0;
    int          low_cnt = 0;
    int          high_cnt = 0;
    logic [15:0] last_word = 16'h0000;
    int          last_bits = 0;
    int          last_low = 0;
    int          last_gap = 0;
    int          min_gap = 100000;
    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b0;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (prev_cs && !dac_cs_n) begin
                last_gap = high_cnt;
                if (frames > 0 && high_cnt < min_gap) min_gap = high_cnt;
                low_cnt = 1;
                nbits   = 0;
            end else if (!dac_cs_n) begin
                low_cnt++;
            end
            if (!prev_cs && dac_cs_n) high_cnt = 1;
            else if (dac_cs_n) high_cnt++;
            if (!dac_cs_n && dac_sclk && !prev_sclk) begin
                cap = {cap[14:0], dac_sin};
                nbits++;
            end
            if (!prev_cs && dac_cs_n) begin
                frames++;
                last_word = cap;
                last_bits = nbits;
                last_low  = low_cnt;
            end
            prev_cs   = dac_cs_n;
            prev_sclk = dac_sclk;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_pps();
        pps = 1'b1;
        step(1);
        pps = 1'b0;
    endtask

    task automatic ms_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            ms = 1'b1;
            step(1);
            ms = 1'b0;
            step(1);
        end
    endtask

    task automatic hold_val(input logic [15:0] v);
        val = v;
        for (int i = 0; i < 2000; i++) begin
            ms  = (i % 200 == 0);
            pps = (i == 1100);
            step(1);
        end
        ms  = 1'b0;
        pps = 1'b0;
    endtask

    initial begin : stim
        ena = 1'b1;
        step(2);
        pulse_pps();
        step(3);
        ms = 1'b1;
        step(2);
        ms = 1'b0;
        step(4);
        chk("reset_no_frames", frames, 0);
        chk("reset_cs_n", int'(dac_cs_n), 1);
        rst = 1'b0;
        step(3);

        pulse_pps();
        step(150);
        chk("zero_frames", frames, 1);
        chk("zero_word", int'(last_word), 16'h0000);
        chk("zero_bits", last_bits, 16);
        chk("zero_cs_low", last_low, 132);

        val = 16'hAAAA;
        ms_ticks(200);
        chk("aaaa_frames", frames, 2);
        chk("aaaa_word", int'(last_word), 16'hAAAA);
        chk("aaaa_bits", last_bits, 16);
        ms_ticks(150);
        chk("aaaa_no_repeat", frames, 2);
        val = 16'h5555;
        ms_ticks(200);
        chk("5555_frames", frames, 3);
        chk("5555_word", int'(last_word), 16'h5555);

        min_gap = 100000;
        hold_val(16'hA5A5);
        chk("a5a5_frames", frames, 5);
        chk("a5a5_word", int'(last_word), 16'hA5A5);
        hold_val(16'h5A5A);
        chk("5a5a_frames", frames, 7);
        chk("5a5a_word", int'(last_word), 16'h5A5A);
        chk("gap_min_ge8", int'(min_gap >= 8), 1);

        pulse_pps();
        step(30);
        pulse_pps();
        step(400);
        chk("pend_frames", frames, 9);
        chk("pend_gap", last_gap, 9);
        chk("pend_word", int'(last_word), 16'h5A5A);
        chk("pend_bits", last_bits, 16);

        ena = 1'b0;
        val = 16'h1234;
        pulse_pps();
        ms_ticks(150);
        chk("ena_off_idle", frames, 9);
        ena = 1'b1;
        dac_tri = 1'b1;
        pulse_pps();
        ms_ticks(150);
        chk("tri_idle", frames, 9);
        dac_tri = 1'b0;
        step(2);
        ms_ticks(1);
        step(200);
        chk("tri_refresh_frames", frames, 10);
        chk("tri_refresh_word", int'(last_word), 16'h1234);

        pulse_pps();
        step(20);
        ena = 1'b0;
        pulse_pps();
        step(400);
        chk("ena_fall_frames", frames, 11);
        chk("ena_fall_bits", last_bits, 16);
        ena = 1'b1;

        pulse_pps();
        step(40);
        dac_tri = 1'b1;
        step(1);
        chk("tri_abort_cs_n", int'(dac_cs_n), 1);
        chk("tri_abort_sclk", int'(dac_sclk), 0);
        dac_tri = 1'b0;
        step(200);
        chk("tri_abort_frames", frames, 12);

        pulse_pps();
        step(50);
        rst = 1'b1;
        step(1);
        chk("rst_abort_pins", int'({dac_cs_n, dac_sclk, dac_sin}), 3'b100);
        step(1);
        rst = 1'b0;
        step(5);
        pulse_pps();
        step(200);
        chk("recover_frames", frames, 14);
        chk("recover_word", int'(last_word), 16'h1234);
        chk("recover_bits", last_bits, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
